// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider (clk_div_prog).
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

  // High-phase length of a period of n cycles: ceil(n/2).
  function automatic logic [31:0] hi_cycles(input logic [31:0] n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/clk_div_shadow.sv
// Divisor shadow register: clamps and holds a pending divisor, swaps it into
// the active divisor on i_apply (or immediately while idle) and strobes o_ack.
module clk_div_shadow
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 26,
  parameter int DIV_DEFAULT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_idle,
  input  logic             i_apply,
  output logic [CNT_W-1:0] o_div,
  output logic             o_ack
);

  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend_val;
  logic             r_pend;
  logic             r_idle_ack;
  logic             r_ack;
  logic [CNT_W-1:0] w_clamped;
  logic [CNT_W-1:0] w_idle_next;

  assign w_clamped   = (i_val < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : i_val;
  assign w_idle_next = i_load ? w_clamped : r_pend_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= CNT_W'(DIV_DEFAULT);
      r_pend     <= 1'b0;
      r_idle_ack <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      r_idle_ack <= 1'b0;
      r_ack      <= r_idle_ack;
      if (i_idle) begin
        // No period in flight: a new or leftover pending divisor takes effect now.
        if (i_load || r_pend) begin
          r_div      <= w_idle_next;
          r_pend     <= 1'b0;
          r_idle_ack <= 1'b1;
        end
      end else begin
        if (i_apply && r_pend) begin
          r_div  <= r_pend_val;
          r_pend <= 1'b0;
          r_ack  <= 1'b1;
        end
        // A load on the wrap edge re-arms pending for the following wrap.
        if (i_load) r_pend <= 1'b1;
      end
    end
  end

  // NOTE: the pending value is only consumed while r_pend is set, so it is a
  // plain data register with no reset; keep it out of the reset block.
  always_ff @(posedge clk) begin
    if (i_load && !i_idle) r_pend_val <= w_clamped;
  end

  assign o_div = r_div;
  assign o_ack = r_ack;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with graceful stop.
// Optional macro CLK_DIV_PERIOD_CNT_EN adds a 16-bit o_tick counter port.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 26,
  parameter int DIV_DEFAULT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
`ifdef CLK_DIV_PERIOD_CNT_EN
  output logic [15:0]      period_cnt,
`endif
  output logic             o_clk,
  output logic             o_tick,
  output logic             running
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clk;
  logic             r_tick;
  logic [CNT_W-1:0] w_div;
  logic [CNT_W-1:0] w_hi;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_wrap;

  assign w_hi      = CNT_W'(hi_cycles(32'(w_div)));
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_wrap    = (r_state != IDLE) && (r_cnt == w_div - 1'b1);

  clk_div_shadow #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (div_load),
    .i_val   (div_val),
    .i_idle  (r_state == IDLE),
    .i_apply (w_wrap),
    .o_div   (w_div),
    .o_ack   (div_ack)
  );

  // NOTE: every flop here uses non-blocking assignment so all of them sample
  // the pre-edge values of r_cnt/r_state regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_clk <= 1'b0;
          if (en) begin
            r_state <= RUN;
            r_clk   <= 1'b1;
            r_tick  <= 1'b1;
          end
        end
        default: begin
          if (w_wrap) begin
            r_cnt <= '0;
            if (en) begin
              r_state <= RUN;
              r_clk   <= 1'b1;
              r_tick  <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_clk   <= 1'b0;
            end
          end else begin
            // Mid-period: RUN and DRAIN count identically, en only picks the label.
            r_cnt   <= w_cnt_inc;
            r_clk   <= (w_cnt_inc < w_hi);
            r_state <= en ? RUN : DRAIN;
          end
        end
      endcase
    end
  end

`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [15:0] r_period_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_period_cnt <= '0;
    else if (r_tick) r_period_cnt <= r_period_cnt + 16'd1;
  end

  assign period_cnt = r_period_cnt;
`endif

  assign o_clk   = r_clk;
  assign o_tick  = r_tick;
  assign running = (r_state != IDLE);

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: stimulus queues expected tick/ack events,
// a negedge monitor pops and compares them, plus direct level checks.
module tb_clk_div_prog;

  localparam int CNT_W = 26;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             div_ack;
  logic             o_clk;
  logic             o_tick;
  logic             running;
`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [15:0]      period_cnt;
`endif

  clk_div_prog #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .div_val    (div_val),
    .div_load   (div_load),
    .div_ack    (div_ack),
`ifdef CLK_DIV_PERIOD_CNT_EN
    .period_cnt (period_cnt),
`endif
    .o_clk      (o_clk),
    .o_tick     (o_tick),
    .running    (running)
  );

  typedef struct {
    int cyc;
    bit tick;
    bit ack;
    int prev_hi;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hi_cnt  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic push_exp(input int c, input bit t, input bit a, input int h);
    exp_t e;
    e.cyc = c; e.tick = t; e.ack = a; e.prev_hi = h;
    exp_q.push_back(e);
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every tick or ack must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_tick || div_ack) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event @cyc %0d: tick=%0d ack=%0d, none expected",
                   cyc, o_tick, div_ack);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("event_cyc", cyc, e.cyc);
          check("event_tick", int'(o_tick), int'(e.tick));
          check("event_ack", int'(div_ack), int'(e.ack));
          if (o_tick && e.prev_hi >= 0) check("hi_cycles", hi_cnt, e.prev_hi);
        end
      end
      if (o_tick)     hi_cnt = 1;
      else if (o_clk) hi_cnt = hi_cnt + 1;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d, e, f, g;
    rst_n    = 1'b0;
    en       = 1'b0;
    div_val  = '0;
    div_load = 1'b0;

    // Reset state
    at_cyc(3);
    check("rst_o_clk", int'(o_clk), 0);
    check("rst_o_tick", int'(o_tick), 0);
    check("rst_div_ack", int'(div_ack), 0);
    check("rst_running", int'(running), 0);
    rst_n = 1'b1;

    // Default N=32: 16 high / 16 low, first tick one cycle after en
    c = 5;
    at_cyc(c);
    en = 1'b1;
    push_exp(c + 1, 1, 0, -1);
    push_exp(c + 33, 1, 0, 16);
    push_exp(c + 65, 1, 0, 16);
    at_cyc(c + 70);
    en = 1'b0;
    at_cyc(c + 96);
    check("n32_running_before_stop", int'(running), 1);
    at_cyc(c + 97);
    check("n32_running_after_stop", int'(running), 0);
    check("n32_o_clk_after_stop", int'(o_clk), 0);

    // Load 5 in IDLE, ack one cycle later; then run at N=5
    d = c + 100;
    at_cyc(d);
    div_val  = CNT_W'(5);
    div_load = 1'b1;
    push_exp(d + 2, 0, 1, -1);
    at_cyc(d + 1);
    div_load = 1'b0;
    at_cyc(d + 3);
    en = 1'b1;
    push_exp(d + 4, 1, 0, -1);
    push_exp(d + 9, 1, 0, 3);
    push_exp(d + 14, 1, 0, 3);

    // Switch to N=4 at a wrap
    at_cyc(d + 15);
    div_val  = CNT_W'(4);
    div_load = 1'b1;
    push_exp(d + 19, 1, 1, 3);
    push_exp(d + 23, 1, 0, 2);
    push_exp(d + 27, 1, 0, 2);
    at_cyc(d + 16);
    div_load = 1'b0;

    // Two loads in one period (9 then 10): last wins, single ack, period 4 intact
    at_cyc(d + 28);
    div_val  = CNT_W'(9);
    div_load = 1'b1;
    at_cyc(d + 29);
    div_val  = CNT_W'(10);
    at_cyc(d + 30);
    div_load = 1'b0;
    push_exp(d + 31, 1, 1, 2);
    push_exp(d + 41, 1, 0, 5);
    push_exp(d + 51, 1, 0, 5);

    // Switch to N=8, drop en at cnt=1 -> drain to IDLE without a tick
    at_cyc(d + 52);
    div_val  = CNT_W'(8);
    div_load = 1'b1;
    at_cyc(d + 53);
    div_load = 1'b0;
    e = d + 61;
    push_exp(e, 1, 1, 5);
    at_cyc(e + 1);
    en = 1'b0;
    at_cyc(e + 3);
    check("drain_o_clk_high_cnt3", int'(o_clk), 1);
    at_cyc(e + 4);
    check("drain_o_clk_low_cnt4", int'(o_clk), 0);
    at_cyc(e + 7);
    check("drain_running_cnt7", int'(running), 1);
    at_cyc(e + 8);
    check("drain_running_after_wrap", int'(running), 0);

    // Restart, drop en at cnt=1 and re-assert at cnt=5: seamless continuation
    at_cyc(e + 10);
    en = 1'b1;
    f = e + 11;
    push_exp(f, 1, 0, 4);
    at_cyc(f + 1);
    en = 1'b0;
    at_cyc(f + 5);
    en = 1'b1;
    push_exp(f + 8, 1, 0, 4);
    push_exp(f + 16, 1, 0, 4);
    at_cyc(f + 7);
    check("redrain_running", int'(running), 1);

    // div_val=0 clamps to 2
    at_cyc(f + 17);
    div_val  = '0;
    div_load = 1'b1;
    at_cyc(f + 18);
    div_load = 1'b0;
    push_exp(f + 24, 1, 1, 4);
    push_exp(f + 26, 1, 0, 1);
    push_exp(f + 28, 1, 0, 1);

    // div_val=1 loaded on a wrap edge: applies at the following wrap
    at_cyc(f + 29);
    div_val  = CNT_W'(1);
    div_load = 1'b1;
    at_cyc(f + 30);
    div_load = 1'b0;
    push_exp(f + 30, 1, 0, 1);
    push_exp(f + 32, 1, 1, 1);
    push_exp(f + 34, 1, 0, 1);

    // Asynchronous reset while o_clk is high
    at_cyc(f + 34);
    check("pre_rst_o_clk", int'(o_clk), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_o_clk", int'(o_clk), 0);
    check("async_rst_o_tick", int'(o_tick), 0);
    check("async_rst_running", int'(running), 0);

    // After release the divisor is back to 32
    g = f + 37;
    at_cyc(g);
    rst_n = 1'b1;
    push_exp(g + 1, 1, 0, -1);
    push_exp(g + 33, 1, 0, 16);
    at_cyc(g + 40);
    en = 1'b0;
    at_cyc(g + 70);
    check("final_running", int'(running), 0);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
